mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one line-wide memory port between two cache requesters: port 0 = I-cache, port 1 = D-cache.
//  Serialises readM/writeM line transfers, routes address and data, returns a one-cycle ready to the owner.
//  Sits between the cache pair and main memory in the cached multi-cycle CPU.
//  Tri-state adaptation to the inout line buses is done at the top level; all ports here are unidirectional.
// PARAMETERS
//  ADDR_W  16  address width in bits (word address, same as the CPU address)
//  LINE_W  64  cache line / memory bus width in bits
// PORTS
//  clk          in   1       clock, all logic on posedge
//  reset        in   1       synchronous, active-high reset
//  req_read     in   2       per-port line read request, held until ready
//  req_write    in   2       per-port line write request, held until ready
//  req_addr0    in   ADDR_W  port 0 address
//  req_addr1    in   ADDR_W  port 1 address
//  req_wdata0   in   LINE_W  port 0 write line
//  req_wdata1   in   LINE_W  port 1 write line
//  req_ready    out  2       one-cycle completion pulse per port
//  req_rdata    out  LINE_W  read line, valid while the owner's req_ready is high
//  mem_read     out  1       memory read strobe (readM)
//  mem_write    out  1       memory write strobe (writeM)
//  mem_addr     out  ADDR_W  latched address
//  mem_wdata    out  LINE_W  latched write line
//  mem_rdata    in   LINE_W  memory read line
//  mem_ready    in   1       memory completion (readyM); at most one cycle per transfer
// BEHAVIOUR
//  - Reset values: state=IDLE; mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, req_ready=0, req_rdata=0, owner=1.
//  - FSM states: IDLE -> BUSY -> RESP -> IDLE. All outputs are registered.
//  - IDLE: a port requests when req_read|req_write is high.
//    - On any request, pick a winner and latch owner, op, addr and wdata.
//    - Set mem_read or mem_write at the next edge, then go to BUSY.
//    - Request-to-strobe latency is 1 cycle.
//  - Op select: write has priority if a port asserts both read and write (the port's dirty-eviction ordering).
//  - BUSY: hold strobe, addr and wdata stable until mem_ready.
//    - On the mem_ready edge: clear the strobe, latch mem_rdata into req_rdata (reads only), go to RESP.
//  - RESP: req_ready[owner]=1 for exactly one cycle; the other bit stays 0. Then go to IDLE.
//  - The requester drops its request on the same edge that ends RESP.
//    - That request is not seen again in IDLE, so there is no double grant.
//  - The losing port's request stays pending. It is granted on the next IDLE; no request is ever dropped.
//  - Minimum turnaround: 3 cycles (IDLE, BUSY with mem_ready=1, RESP).
//  - A request that deasserts while BUSY does not abort the transfer. It completes; ready is still pulsed.
//  - mem_ready while IDLE or RESP is ignored.
//  - Reset mid-transfer: strobes drop at that edge, FSM returns to IDLE. Memory is reset together with the arbiter.
//  - req_rdata holds its last value outside RESP; writes leave it unchanged.
// CONFIGURATION
//  ARB_RR_EN defined: round-robin.
//    - On a simultaneous request, grant the port != owner of the last completed transfer.
//    - owner resets to 1, so port 0 wins the first tie.
//  ARB_RR_EN undefined: fixed priority. Port 1 (D-cache) always wins a tie.
//  The single-requester path is identical in both builds.
// STRUCTURE
//  Shared package mem_arb_pkg holds:
//    - state encoding localparams ARB_IDLE=2'd0, ARB_BUSY=2'd1, ARB_RESP=2'd2;
//    - port ids PORT_I=1'b0, PORT_D=1'b1;
//    - default ADDR_W/LINE_W.
//  One sub-module, arb_pick2: combinational 2-way winner select (inputs: requests, last owner; output: grant id).
//  It contains the ARB_RR_EN switch. The FSM and datapath registers stay in mem_arbiter.
// TESTING
//  1. Port 0 read 0x0010, mem_ready 2 cycles after strobe, mem_rdata=64'h1111_2222_3333_4444
//     -> mem_read=1 with mem_addr=0x0010; req_ready=2'b01 for one cycle; req_rdata=64'h1111_2222_3333_4444.
//  2. Port 1 read and write both high, addr 0x0024, wdata=64'hDEAD_BEEF_0000_0001
//     -> mem_write=1 only, mem_wdata matches; req_ready=2'b10; req_rdata unchanged.
//  3. Both ports read in the same cycle, not ARB_RR_EN -> port 1 served first, then port 0.
//     -> Two req_ready pulses, 2'b10 then 2'b01.
//  4. ARB_RR_EN, both ports request continuously for 4 transfers -> grants alternate 0,1,0,1.
//  5. reset=1 while BUSY with mem_write=1 -> next cycle mem_write=0, state IDLE, req_ready=0.
//     -> A late mem_ready produces no req_ready.
//  6. mem_ready pulsed while IDLE with no requests -> no strobe and no req_ready; req_rdata unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port cache/memory line arbiter:
// state encoding, port ids and default bus widths.
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int LINE_W_DEF = 64;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_BUSY = 2'd1;
  localparam logic [1:0] ARB_RESP = 2'd2;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = ARB_IDLE,
    ST_BUSY = ARB_BUSY,
    ST_RESP = ARB_RESP
  } arb_state_e;
endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way winner select. Build option: ARB_RR_EN selects
// round-robin tie-breaking; otherwise the D-cache port wins every tie.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_owner_i,
  output logic       gnt_o
);
`ifndef ARB_RR_EN
  logic unused_last_owner;
  assign unused_last_owner = last_owner_i;
`endif

  always_comb begin
    gnt_o = PORT_I;
    if (req_i == 2'b11) begin
`ifdef ARB_RR_EN
      gnt_o = ~last_owner_i;
`else
      gnt_o = PORT_D;
`endif
    end else if (req_i[1]) begin
      gnt_o = PORT_D;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache (port 0) and D-cache (port 1) line transfers onto one
// memory port. Tie policy comes from arb_pick2 (build option ARB_RR_EN).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_read,
  input  logic [1:0]        req_write,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [LINE_W-1:0] req_wdata0,
  input  logic [LINE_W-1:0] req_wdata1,
  output logic [1:0]        req_ready,
  output logic [LINE_W-1:0] req_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);
  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        req_ready_q, req_ready_d;
  logic [LINE_W-1:0] req_rdata_q, req_rdata_d;

  logic [1:0] req_any;
  logic       gnt;

  assign req_any = req_read | req_write;

  arb_pick2 u_pick (
    .req_i        (req_any),
    .last_owner_i (owner_q),
    .gnt_o        (gnt)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    req_ready_d = 2'b00;
    req_rdata_d = req_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_any) begin
          owner_d = gnt;
          // write first: a dirty eviction must reach memory before the refill
          mem_write_d = req_write[gnt];
          mem_read_d  = ~req_write[gnt];
          mem_addr_d  = gnt ? req_addr1 : req_addr0;
          mem_wdata_d = gnt ? req_wdata1 : req_wdata0;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (mem_read_q) req_rdata_d = mem_rdata;
          req_ready_d = owner_q ? 2'b10 : 2'b01;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= PORT_D;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      req_ready_q <= 2'b00;
      req_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      req_ready_q <= req_ready_d;
      req_rdata_q <= req_rdata_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign req_ready = req_ready_q;
  assign req_rdata = req_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; tie expectations follow ARB_RR_EN.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_read, req_write, req_ready;
  logic [15:0] req_addr0, req_addr1, mem_addr;
  logic [63:0] req_wdata0, req_wdata1, req_rdata, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_ready;

  int          errs = 0;
  int          checks = 0;
  logic        last_own;
  logic [63:0] exp_rdata;

  mem_arbiter #(.ADDR_W(16), .LINE_W(64)) dut (
    .clk(clk), .reset(reset),
    .req_read(req_read), .req_write(req_write),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_ready(req_ready), .req_rdata(req_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic tie_win();
`ifdef ARB_RR_EN
    return ~last_own;
`else
    return 1'b1;
`endif
  endfunction

  // Serve one transfer for port p; called on the negedge where its request is visible.
  task automatic serve(input logic p, input logic wr, input logic [15:0] addr,
                       input logic [63:0] wdata, input logic [63:0] rd, input int dly);
    int n = 0;
    while (!(mem_read || mem_write) && n < 6) begin
      cyc();
      n++;
    end
    chk("latency", 64'(n), 64'd1);
    chk("mem_read", {63'd0, mem_read}, {63'd0, !wr});
    chk("mem_write", {63'd0, mem_write}, {63'd0, wr});
    chk("mem_addr", {48'd0, mem_addr}, {48'd0, addr});
    if (wr) chk("mem_wdata", mem_wdata, wdata);
    for (int i = 1; i < dly; i++) begin
      cyc();
      chk("hold", {46'd0, mem_read, mem_write, mem_addr}, {46'd0, !wr, wr, addr});
    end
    mem_rdata = rd;
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    mem_rdata = 64'hBADB_ADBA_DBAD_BADB;
    if (!wr) exp_rdata = rd;
    chk("req_ready", {62'd0, req_ready}, p ? 64'd2 : 64'd1);
    chk("req_rdata", req_rdata, exp_rdata);
    chk("strobe_clr", {62'd0, mem_read, mem_write}, 64'd0);
    req_read[p]  = 1'b0;
    req_write[p] = 1'b0;
    last_own = p;
    cyc();
    chk("ready_drop", {62'd0, req_ready}, 64'd0);
  endtask

  initial begin
    logic w;
    reset = 1'b1; req_read = 2'b00; req_write = 2'b00;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) cyc();
    chk("rst_strobes", {62'd0, mem_read, mem_write}, 64'd0);
    chk("rst_addr", {48'd0, mem_addr}, 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    chk("rst_ready", {62'd0, req_ready}, 64'd0);
    chk("rst_rdata", req_rdata, 64'd0);
    reset = 1'b0;
    exp_rdata = '0;
    last_own = 1'b1;
    cyc();

    // 1: port 0 read, memory answers two cycles after the strobe
    req_addr0 = 16'h0010; req_read = 2'b01;
    serve(1'b0, 1'b0, 16'h0010, 64'd0, 64'h1111_2222_3333_4444, 2);

    // 2: port 1 read+write -> write only, rdata untouched
    req_addr1 = 16'h0024; req_wdata1 = 64'hDEAD_BEEF_0000_0001;
    req_read = 2'b10; req_write = 2'b10;
    serve(1'b1, 1'b1, 16'h0024, 64'hDEAD_BEEF_0000_0001, 64'h5555_6666_7777_8888, 1);

    // 6: stray mem_ready while idle
    mem_rdata = 64'hFFFF_0000_FFFF_0000; mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    chk("idle_strobe", {62'd0, mem_read, mem_write}, 64'd0);
    chk("idle_ready", {62'd0, req_ready}, 64'd0);
    cyc();
    chk("idle_ready2", {62'd0, req_ready}, 64'd0);
    chk("idle_rdata", req_rdata, exp_rdata);

    // 3: simultaneous reads; loser stays pending and is served next
    req_addr0 = 16'h0100; req_addr1 = 16'h0200; req_read = 2'b11;
    w = tie_win();
    serve(w, 1'b0, w ? 16'h0200 : 16'h0100, 64'd0, 64'hA0A0_0000_0000_0001, 1);
    serve(!w, 1'b0, !w ? 16'h0200 : 16'h0100, 64'd0, 64'hA0A0_0000_0000_0002, 1);

    // 4: both ports request continuously for four transfers
    req_addr0 = 16'h0300; req_addr1 = 16'h0400;
    for (int i = 0; i < 4; i++) begin
      req_read = 2'b11;
      w = tie_win();
      serve(w, 1'b0, w ? 16'h0400 : 16'h0300, 64'd0, 64'hC0C0_0000_0000_0000 + 64'(i), 1);
    end
    req_read = 2'b00;
    cyc();

    // 5: reset while a write is in flight, then a late mem_ready
    req_addr1 = 16'h0ABC; req_wdata1 = 64'h0123_4567_89AB_CDEF; req_write = 2'b10;
    cyc();
    chk("t5_write", {63'd0, mem_write}, 64'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0; req_write = 2'b00;
    last_own = 1'b1; exp_rdata = '0;
    chk("t5_strobe", {62'd0, mem_read, mem_write}, 64'd0);
    chk("t5_ready", {62'd0, req_ready}, 64'd0);
    chk("t5_addr", {48'd0, mem_addr}, 64'd0);
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    chk("t5_late_ready", {62'd0, req_ready}, 64'd0);
    cyc();
    chk("t5_late_ready2", {62'd0, req_ready}, 64'd0);
    chk("t5_late_strobe", {62'd0, mem_read, mem_write}, 64'd0);
    chk("t5_rdata", req_rdata, exp_rdata);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
